oam_dma_engine: RTL and testbench
=================================

Name: oam_dma_engine

Overview:
- Bus-master that copies a block of bytes from a source memory port into OAM, implementing the FF46-style OAM DMA.
- Drives one read port of a source BRAM (registered output, fixed read latency) and port A of the OAM BRAM.
- Sits between the CPU I/O register decode, which supplies the start strobe and page, and the memory blocks.
- Holds busy high for the whole copy so the bus arbiter can block CPU access to everything except HRAM.

Parameters:
LEN, 160, bytes per transfer; destination offsets 0..LEN-1.
RD_LAT, 1, source read latency in clka cycles, from address presented to data valid.
STRIDE, 4, clka cycles per byte slot; must satisfy STRIDE >= RD_LAT+1.

Ports:
clka  in  1  clock; all state changes on rising edge.
rsta  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle strobe; CPU wrote the DMA register.
src_page  in  8  source high byte, sampled when start=1.
rd_en  out  1  source read strobe.
rd_addr  out  16  source byte address {page, offset}.
rd_data  in  8  source data, valid RD_LAT cycles after rd_addr.
wr_en  out  1  OAM write enable (wea).
wr_addr  out  8  OAM offset 0..LEN-1.
wr_data  out  8  OAM write data.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset: asserting rsta at any time, including mid-transfer, forces state to IDLE immediately. All outputs go to 0 and the internal page, index and slot counters clear. No partial write occurs after reset assertion. OAM contents already written stay as they are.
- Page mapping: on start, page_q = (src_page >= 8'hE0) ? src_page - 8'h20 : src_page. Echo RAM region maps onto WRAM.
- States: IDLE, RUN, FINISH.
- IDLE: outputs idle. On start=1, latch page_q, set idx=0 and slot=0, then go to RUN. busy rises the cycle after start.
- RUN, slot counter 0..STRIDE-1, wraps:
  - slot==0: rd_en=1 and rd_addr={page_q, idx}.
  - slot==RD_LAT: wr_en=1, wr_addr=idx, wr_data=rd_data (combinational pass-through of the sampled port).
  - All other slots: rd_en=0 and wr_en=0.
  - At slot==STRIDE-1: if idx==LEN-1, go to FINISH; else idx <= idx+1 and slot <= 0.
- FINISH: done=1 for exactly one cycle and busy=0 from that cycle onward, then return to IDLE.
- Output hold: rd_addr holds its last value between strobes. wr_addr and wr_data are don't-care when wr_en=0.
- Width rules:
  - idx is 8 bits, so LEN <= 256.
  - slot is clog2(STRIDE) bits.
  - rd_addr low byte equals idx; no carry into the page byte.
- Latency: start at cycle T gives the first rd_en at T+1 and the first wr_en at T+1+RD_LAT. done is asserted at T+1+LEN*STRIDE. With defaults that is 641 cycles.
- Restart: start=1 while in RUN or FINISH restarts from idx=0 with the newly sampled page. In-flight data is discarded: no write is issued from the old page in the cycle start is seen. done is not pulsed for the aborted transfer.
- Simultaneous events:
  - start coinciding with the final write slot gives restart priority, and no done pulse occurs.
  - rsta overrides start.
- Never asserts rd_en and wr_en for the same idx in the same cycle unless RD_LAT=0, which is illegal.

Decomposition:
- Shared package holds:
  - Constants OAM_DMA_LEN=160, ECHO_BASE=8'hE0 and ECHO_OFS=8'h20.
  - State enum dma_state_t {IDLE, RUN, FINISH}.
- One natural sub-module: dma_slot_timer, which holds the slot counter and emits rd_slot, wr_slot and last_slot strobes from STRIDE and RD_LAT.

Test Plan:
- Basic copy: preload source 0xC000..0xC09F with byte=offset^8'h5A. Pulse start with src_page=8'hC0. Required:
  - 160 OAM writes, each with wr_addr=n and wr_data=n^8'h5A.
  - done exactly at start+641.
  - busy high for 640 cycles.
- Echo mapping: src_page=8'hFE. Required: rd_addr runs 16'hDE00..16'hDE9F.
- Restart mid-transfer: start with page 8'h80, then start with page 8'h90 while the write of idx 50 is in progress. Required:
  - No write of idx 50 from page 8'h80.
  - Writes resume at idx 0 from 16'h9000.
  - Exactly one done pulse, 641 cycles after the second start.
- Reset mid-transfer: assert rsta at idx 20. Required:
  - busy, wr_en, rd_en and done all 0 asynchronously.
  - OAM offsets 0..19 hold new data; offset 20 onward unchanged (8'hEE).
- Parameter sweep: RD_LAT=2 and STRIDE=3. Required: wr_en occurs 2 cycles after each rd_en with correct data, and done at start+1+480.
- Back-to-back: pulse start in the FINISH cycle. Required: done pulse suppressed, new transfer begins, busy deasserts only after the second transfer completes.

Source files
------------

// File: rtl/oam_dma_engine_pkg.sv
// Shared constants, FSM state type and page-mapping helper for the OAM DMA engine.
// The source page is remapped once at start so the datapath never sees echo-RAM pages.
package oam_dma_engine_pkg;

    localparam int         OAM_DMA_LEN = 160;
    localparam logic [7:0] ECHO_BASE   = 8'hE0;
    localparam logic [7:0] ECHO_OFS    = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } dma_state_t;

    // Echo RAM (E000-FFFF) aliases WRAM, so those pages are folded down by 0x20.
    function automatic logic [7:0] map_src_page(input logic [7:0] page);
        return (page >= ECHO_BASE) ? page - ECHO_OFS : page;
    endfunction

endpackage

// File: rtl/dma_slot_timer.sv
// Per-byte slot counter for the OAM DMA: counts 0..STRIDE-1 and flags the
// read-issue slot, the write slot (RD_LAT after the read) and the final slot.
module dma_slot_timer
    import oam_dma_engine_pkg::*;
#(
    parameter int STRIDE = 4,
    parameter int RD_LAT = 1
) (
    input  logic clka,
    input  logic rsta,
    input  logic clear,
    input  logic advance,
    output logic rd_slot,
    output logic wr_slot,
    output logic last_slot
);

    localparam int            SW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [SW-1:0] SLOT_WR = SW'(RD_LAT);
    localparam logic [SW-1:0] SLOT_LS = SW'(STRIDE - 1);

    logic [SW-1:0] slot_q;
    logic [SW-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d = '0;
        end else if (advance) begin
            slot_d = last_slot ? '0 : slot_q + 1'b1;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign rd_slot   = (slot_q == '0);
    assign wr_slot   = (slot_q == SLOT_WR);
    assign last_slot = (slot_q == SLOT_LS);

endmodule

// File: rtl/oam_dma_engine.sv
// FF46-style OAM DMA master: copies LEN bytes from {page, 00..LEN-1} of the
// source BRAM into OAM, one byte every STRIDE cycles, with busy held for the arbiter.
module oam_dma_engine
    import oam_dma_engine_pkg::*;
#(
    parameter int LEN    = OAM_DMA_LEN,
    parameter int RD_LAT = 1,
    parameter int STRIDE = 4
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        start,
    input  logic [7:0]  src_page,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] rd_addr_q, rd_addr_d;

    logic in_run;
    logic rd_slot;
    logic wr_slot;
    logic last_slot;

    assign in_run = (state_q == RUN);

    dma_slot_timer #(
        .STRIDE (STRIDE),
        .RD_LAT (RD_LAT)
    ) u_slot_timer (
        .clka      (clka),
        .rsta      (rsta),
        .clear     (start),
        .advance   (in_run),
        .rd_slot   (rd_slot),
        .wr_slot   (wr_slot),
        .last_slot (last_slot)
    );

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start strobe restarts from any state, pre-empting the FINISH transition.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = (last_slot && idx_q == LAST_IDX) ? FINISH : RUN;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are masked while start is high so nothing from an aborted copy lands in OAM.
    always_comb begin
        rd_en   = in_run && rd_slot && !start;
        wr_en   = in_run && wr_slot && !start;
        wr_addr = wr_en ? idx_q : 8'h00;
        wr_data = wr_en ? rd_data : 8'h00;
        rd_addr = rd_en ? {page_q, idx_q} : rd_addr_q;
        busy    = in_run || (state_q == FINISH && start);
        done    = (state_q == FINISH) && !start;
    end

    always_comb begin
        page_d    = start ? map_src_page(src_page) : page_q;
        rd_addr_d = rd_addr;
        idx_d     = idx_q;
        if (start) begin
            idx_d = 8'h00;
        end else if (in_run && last_slot && idx_q != LAST_IDX) begin
            idx_d = idx_q + 8'h01;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            rd_addr_q <= 16'h0000;
        end else begin
            page_q    <= page_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
        end
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed/randomized bench for oam_dma_engine: a transfer-level reference model
// predicts every read, write, done pulse and busy window from the start history.
module tb_oam_dma_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [7:0]  src_page = 8'h00;

    logic        rd_en0, wr_en0, busy0, done0;
    logic [15:0] rd_addr0;
    logic [7:0]  rd_data0, wr_addr0, wr_data0;
    logic        rd_en1, wr_en1, busy1, done1;
    logic [15:0] rd_addr1;
    logic [7:0]  rd_data1, wr_addr1, wr_data1;

    logic [7:0]  src_mem [0:65535];
    logic [7:0]  oam [0:255];
    logic        oam_fill = 1'b0;
    logic [7:0]  pipe0, p1a, p1b;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct packed {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t        rd_log[$];
    ev_t        wr_log[$];
    int         done_log[$];
    int         busy_cnt, busy_first, busy_last;
    int         st_cyc[$];
    logic [7:0] st_page[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oam_dma_engine dut0 (
        .clka(clk), .rsta(rst), .start(start0), .src_page(src_page),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .busy(busy0), .done(done0)
    );

    oam_dma_engine #(.LEN(160), .RD_LAT(2), .STRIDE(3)) dut1 (
        .clka(clk), .rsta(rst), .start(start1), .src_page(src_page),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .done(done1)
    );

    assign rd_data0 = pipe0;
    assign rd_data1 = p1b;

    // Source BRAMs with registered output (latency 1 and 2) and the shared OAM.
    always @(posedge clk) begin
        if (rd_en0) pipe0 <= src_mem[rd_addr0];
        if (rd_en1) p1a <= src_mem[rd_addr1];
        p1b <= p1a;
        if (oam_fill) begin
            for (int i = 0; i < 256; i++) oam[i] <= 8'hEE;
        end else begin
            if (wr_en0) oam[wr_addr0] <= wr_data0;
            if (wr_en1) oam[wr_addr1] <= wr_data1;
        end
    end

    always @(negedge clk) begin
        if (rd_en0) rd_log.push_back('{cyc, rd_addr0, 8'h00});
        if (rd_en1) rd_log.push_back('{cyc, rd_addr1, 8'h00});
        if (wr_en0) wr_log.push_back('{cyc, {8'h00, wr_addr0}, wr_data0});
        if (wr_en1) wr_log.push_back('{cyc, {8'h00, wr_addr1}, wr_data1});
        if (done0 || done1) done_log.push_back(cyc);
        if (busy0 || busy1) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
    end

    function automatic logic [7:0] ref_map(input logic [7:0] p);
        return (p >= 8'hE0) ? p - 8'h20 : p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_start(input logic [7:0] p, input bit sel);
        if (sel) start1 = 1'b1;
        else     start0 = 1'b1;
        src_page = p;
        st_cyc.push_back(cyc);
        st_page.push_back(p);
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic new_scenario();
        rd_log.delete();
        wr_log.delete();
        done_log.delete();
        busy_cnt   = 0;
        busy_first = -1;
        busy_last  = -1;
        st_cyc.delete();
        st_page.delete();
    endtask

    // Expected events from the start history: byte n of a copy begun in cycle s is
    // read at s+1+n*stride and written lat cycles later; a later start cancels anything
    // of the old copy that falls on or after its own cycle.
    task automatic check_run(input int len, input int stride, input int lat, input string tag);
        ev_t        erd[$];
        ev_t        ewr[$];
        int         edone[$];
        int         s, nxt, tr, tw, td, ebusy;
        logic [7:0] mp;
        ebusy = 0;
        for (int k = 0; k < st_cyc.size(); k++) begin
            s   = st_cyc[k];
            mp  = ref_map(st_page[k]);
            nxt = (k + 1 < st_cyc.size()) ? st_cyc[k+1] : 32'h7fffffff;
            for (int n = 0; n < len; n++) begin
                tr = s + 1 + n * stride;
                tw = tr + lat;
                if (tr < nxt) erd.push_back('{tr, {mp, 8'(n)}, 8'h00});
                if (tw < nxt) ewr.push_back('{tw, 16'(n), src_mem[{mp, 8'(n)}]});
            end
            td = s + 1 + len * stride;
            if (td < nxt) edone.push_back(td);
            ebusy += (k + 1 < st_cyc.size()) ? (nxt - s) : len * stride;
        end
        check({tag, "_rd_count"}, 64'(rd_log.size()), 64'(erd.size()));
        for (int i = 0; i < erd.size() && i < rd_log.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), 64'(rd_log[i]), 64'(erd[i]));
        check({tag, "_wr_count"}, 64'(wr_log.size()), 64'(ewr.size()));
        for (int i = 0; i < ewr.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(wr_log[i]), 64'(ewr[i]));
        check({tag, "_done_count"}, 64'(done_log.size()), 64'(edone.size()));
        for (int i = 0; i < edone.size() && i < done_log.size(); i++)
            check($sformatf("%s_done_cyc%0d", tag, i), 64'(done_log[i]), 64'(edone[i]));
        check({tag, "_busy_cnt"}, 64'(busy_cnt), 64'(ebusy));
        check({tag, "_busy_first"}, 64'(busy_first), 64'(st_cyc[0] + 1));
        check({tag, "_busy_last"}, 64'(busy_last), 64'(st_cyc[st_cyc.size()-1] + len * stride));
        mp = ref_map(st_page[st_page.size()-1]);
        for (int n = 0; n < len; n++)
            check($sformatf("%s_oam%0d", tag, n), 64'(oam[n]), 64'(src_mem[{mp, 8'(n)}]));
    endtask

    initial begin
        int         s, t2;
        logic [7:0] p;

        for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
        for (int n = 0; n < 160; n++) src_mem[16'hC000 + n] = 8'(n) ^ 8'h5A;

        rst = 1'b1;
        tick();
        tick();
        check("rst_busy",    64'(busy0),    64'(0));
        check("rst_done",    64'(done0),    64'(0));
        check("rst_rd_en",   64'(rd_en0),   64'(0));
        check("rst_wr_en",   64'(wr_en0),   64'(0));
        check("rst_rd_addr", 64'(rd_addr0), 64'(0));
        check("rst_wr_addr", 64'(wr_addr0), 64'(0));
        check("rst_wr_data", 64'(wr_data0), 64'(0));
        check("rst_busy1",   64'(busy1),    64'(0));
        rst = 1'b0;
        tick();

        // Basic copy from page C0.
        new_scenario();
        pulse_start(8'hC0, 1'b0);
        goto_cycle(st_cyc[0] + 660);
        check("basic_done_at_641", 64'(done_log.size() > 0 ? done_log[0] - st_cyc[0] : -1), 64'(641));
        check_run(160, 4, 1, "basic");

        // Echo page folds onto WRAM.
        new_scenario();
        pulse_start(8'hFE, 1'b0);
        goto_cycle(st_cyc[0] + 660);
        check("echo_first_addr", 64'(rd_log.size() > 0 ? rd_log[0].addr : 16'h0), 64'(16'hDE00));
        check_run(160, 4, 1, "echo");

        // Random page.
        new_scenario();
        pulse_start(8'($urandom), 1'b0);
        goto_cycle(st_cyc[0] + 660);
        check_run(160, 4, 1, "rand");

        // Restart on the cycle idx 50 is being written.
        new_scenario();
        pulse_start(8'h80, 1'b0);
        goto_cycle(st_cyc[0] + 1 + 50 * 4 + 1);
        check("restart_pre_wr_en",   64'(wr_en0),   64'(1));
        check("restart_pre_wr_addr", 64'(wr_addr0), 64'(50));
        start0   = 1'b1;
        src_page = 8'h90;
        t2       = cyc;
        st_cyc.push_back(cyc);
        st_page.push_back(8'h90);
        #1;
        check("restart_gate_wr_en", 64'(wr_en0), 64'(0));
        tick();
        start0 = 1'b0;
        goto_cycle(t2 + 660);
        check_run(160, 4, 1, "restart");

        // Back-to-back: new start lands in the FINISH cycle.
        new_scenario();
        pulse_start(8'($urandom), 1'b0);
        s = st_cyc[0];
        goto_cycle(s + 641);
        check("b2b_finish_done", 64'(done0), 64'(1));
        p        = 8'($urandom);
        start0   = 1'b1;
        src_page = p;
        st_cyc.push_back(cyc);
        st_page.push_back(p);
        #1;
        check("b2b_done_masked", 64'(done0), 64'(0));
        check("b2b_busy_held",   64'(busy0), 64'(1));
        tick();
        start0 = 1'b0;
        goto_cycle(s + 641 + 660);
        check_run(160, 4, 1, "b2b");

        // Parameter sweep instance: RD_LAT=2, STRIDE=3.
        new_scenario();
        pulse_start(8'($urandom), 1'b1);
        goto_cycle(st_cyc[0] + 500);
        check("sweep_done_at_481", 64'(done_log.size() > 0 ? done_log[0] - st_cyc[0] : -1), 64'(481));
        check_run(160, 3, 2, "sweep");

        // Reset while idx 20 is being written.
        new_scenario();
        oam_fill = 1'b1;
        tick();
        oam_fill = 1'b0;
        p = 8'($urandom_range(0, 8'hDF));
        pulse_start(p, 1'b0);
        s = st_cyc[0];
        goto_cycle(s + 1 + 20 * 4 + 1);
        check("rstmid_pre_wr_en",   64'(wr_en0),   64'(1));
        check("rstmid_pre_wr_addr", 64'(wr_addr0), 64'(20));
        rst = 1'b1;
        #1;
        check("rstmid_busy",    64'(busy0),    64'(0));
        check("rstmid_wr_en",   64'(wr_en0),   64'(0));
        check("rstmid_rd_en",   64'(rd_en0),   64'(0));
        check("rstmid_done",    64'(done0),    64'(0));
        check("rstmid_rd_addr", 64'(rd_addr0), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("rstmid_idle_busy", 64'(busy0), 64'(0));
        check("rstmid_no_done",   64'(done_log.size()), 64'(0));
        for (int n = 0; n < 160; n++)
            check($sformatf("rstmid_oam%0d", n), 64'(oam[n]),
                  64'((n < 20) ? src_mem[{p, 8'(n)}] : 8'hEE));

        // Reset takes precedence over a coincident start.
        rst    = 1'b1;
        start0 = 1'b1;
        src_page = 8'h12;
        tick();
        rst    = 1'b0;
        start0 = 1'b0;
        tick();
        tick();
        check("rst_over_start_busy",  64'(busy0),  64'(0));
        check("rst_over_start_rd_en", 64'(rd_en0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
